// File: rtl/rheed_frame_scheduler.sv
// rheed_frame_scheduler
// Moves one RHEED frame at a time through the crop/normalise/CNN pipeline.
// It checks and latches the crop origin and strobes the pipeline start.
// It then gathers the five per-class CNN bytes and hands them downstream,
// tagged with a running frame id.
// A per-frame watchdog aborts any frame whose pipeline never completes.
module rheed_frame_scheduler #(
    parameter int IN_ROWS        = 20,
    parameter int IN_COLS        = 20,
    parameter int OUT_ROWS       = 20,
    parameter int OUT_COLS       = 20,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                       clk,
    input  logic                       ap_rst_n,
    input  logic                       frame_req,
    input  logic [$clog2(IN_COLS)-1:0] req_crop_x0,
    input  logic [$clog2(IN_ROWS)-1:0] req_crop_y0,
    output logic                       ap_start,
    input  logic                       pipe_ap_ready,
    output logic [$clog2(IN_COLS)-1:0] crop_x0,
    output logic [$clog2(IN_ROWS)-1:0] crop_y0,
    input  logic [4:0]                 cnn_tvalid,
    output logic [4:0]                 cnn_tready,
    input  logic [39:0]                cnn_tdata,
    output logic                       res_tvalid,
    input  logic                       res_tready,
    output logic [39:0]                res_tdata,
    output logic [15:0]                res_tuser,
    output logic                       busy,
    output logic [15:0]                drop_cnt,
    output logic [15:0]                timeout_cnt
);

    localparam int XW = $clog2(IN_COLS);
    localparam int YW = $clog2(IN_ROWS);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    // Largest crop origin that still keeps the whole window inside the frame
    localparam logic [XW-1:0] MAX_X0  = XW'(IN_COLS - OUT_COLS);
    localparam logic [YW-1:0] MAX_Y0  = YW'(IN_ROWS - OUT_ROWS);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_EMIT  = 2'd3;

    logic [1:0]    r_state;
    logic [XW-1:0] r_crop_x0;
    logic [YW-1:0] r_crop_y0;
    logic [4:0]    r_cap;
    logic [39:0]   r_res_data;
    logic [15:0]   r_frame_id;
    logic [15:0]   r_drop_cnt;
    logic [15:0]   r_timeout_cnt;
    logic [WW-1:0] r_wdog;

    logic          w_in_range;
    logic          w_accept;
    logic          w_drop;
    logic          w_wd_expire;
    logic [4:0]    w_tready;
    logic [4:0]    w_fire;
    logic [4:0]    w_cap_next;

    assign w_in_range  = (req_crop_x0 <= MAX_X0) && (req_crop_y0 <= MAX_Y0);
    assign w_accept    = frame_req && (r_state == S_IDLE) && w_in_range;
    assign w_drop      = frame_req && !w_accept;
    assign w_wd_expire = ((r_state == S_START) || (r_state == S_RUN)) && (r_wdog == WD_LAST);
    assign w_tready    = (r_state == S_RUN) ? ~r_cap : 5'b00000;
    assign w_fire      = cnn_tvalid & w_tready;
    assign w_cap_next  = r_cap | w_fire;

    assign ap_start    = (r_state == S_START);
    assign busy        = (r_state != S_IDLE);
    assign res_tvalid  = (r_state == S_EMIT);
    assign cnn_tready  = w_tready;
    assign crop_x0     = r_crop_x0;
    assign crop_y0     = r_crop_y0;
    assign res_tdata   = r_res_data;
    assign res_tuser   = r_frame_id;
    assign drop_cnt    = r_drop_cnt;
    assign timeout_cnt = r_timeout_cnt;

    // Frame sequencing, watchdog, capture bookkeeping and the statistics counters
    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state       <= S_IDLE;
            r_crop_x0     <= '0;
            r_crop_y0     <= '0;
            r_cap         <= '0;
            r_frame_id    <= '0;
            r_drop_cnt    <= '0;
            r_timeout_cnt <= '0;
            r_wdog        <= '0;
        end else begin
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state   <= S_START;
                        r_crop_x0 <= req_crop_x0;
                        r_crop_y0 <= req_crop_y0;
                        r_cap     <= '0;
                        r_wdog    <= '0;
                    end
                end
                S_START, S_RUN: begin
                    if (w_wd_expire) begin
                        r_state    <= S_IDLE;
                        r_cap      <= '0;
                        r_wdog     <= '0;
                        r_frame_id <= r_frame_id + 16'd1;
                        if (r_timeout_cnt != 16'hFFFF) begin
                            r_timeout_cnt <= r_timeout_cnt + 16'd1;
                        end
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                        if (r_state == S_START) begin
                            if (pipe_ap_ready) begin
                                r_state <= S_RUN;
                            end
                        end else begin
                            r_cap <= w_cap_next;
                            if (&w_cap_next) begin
                                r_state <= S_EMIT;
                            end
                        end
                    end
                end
                S_EMIT: begin
                    if (res_tready) begin
                        r_state    <= S_IDLE;
                        r_frame_id <= r_frame_id + 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Per-lane capture of CNN class bytes into the outgoing result word
    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_res_data <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (w_fire[i]) begin
                    r_res_data[8*i +: 8] <= cnn_tdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_rheed_frame_scheduler.sv
// tb_rheed_frame_scheduler
// Directed scenarios for the frame scheduler.
// Inputs are driven on the falling edge and outputs are sampled there as well.
module tb_rheed_frame_scheduler;

    localparam int IN_ROWS        = 20;
    localparam int IN_COLS        = 20;
    localparam int OUT_ROWS       = 16;
    localparam int OUT_COLS       = 16;
    localparam int TIMEOUT_CYCLES = 50;

    logic        clk           = 1'b0;
    logic        ap_rst_n      = 1'b0;
    logic        frame_req     = 1'b0;
    logic [4:0]  req_crop_x0   = '0;
    logic [4:0]  req_crop_y0   = '0;
    logic        ap_start;
    logic        pipe_ap_ready = 1'b0;
    logic [4:0]  crop_x0;
    logic [4:0]  crop_y0;
    logic [4:0]  cnn_tvalid    = '0;
    logic [4:0]  cnn_tready;
    logic [39:0] cnn_tdata     = '0;
    logic        res_tvalid;
    logic        res_tready    = 1'b0;
    logic [39:0] res_tdata;
    logic [15:0] res_tuser;
    logic        busy;
    logic [15:0] drop_cnt;
    logic [15:0] timeout_cnt;

    int compared   = 0;
    int mismatched = 0;

    rheed_frame_scheduler #(
        .IN_ROWS(IN_ROWS), .IN_COLS(IN_COLS), .OUT_ROWS(OUT_ROWS),
        .OUT_COLS(OUT_COLS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .ap_rst_n(ap_rst_n), .frame_req(frame_req),
        .req_crop_x0(req_crop_x0), .req_crop_y0(req_crop_y0),
        .ap_start(ap_start), .pipe_ap_ready(pipe_ap_ready),
        .crop_x0(crop_x0), .crop_y0(crop_y0),
        .cnn_tvalid(cnn_tvalid), .cnn_tready(cnn_tready), .cnn_tdata(cnn_tdata),
        .res_tvalid(res_tvalid), .res_tready(res_tready),
        .res_tdata(res_tdata), .res_tuser(res_tuser),
        .busy(busy), .drop_cnt(drop_cnt), .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    // Drive-only helpers; each returns on a falling edge
    task automatic do_reset();
        ap_rst_n = 1'b0;
        @(negedge clk);
        ap_rst_n = 1'b1;
    endtask

    task automatic start_frame(input logic [4:0] x, input logic [4:0] y);
        @(negedge clk);
        frame_req = 1'b1; req_crop_x0 = x; req_crop_y0 = y;
        @(negedge clk);
        frame_req = 1'b0;
    endtask

    task automatic go_run();
        pipe_ap_ready = 1'b1;
        @(negedge clk);
        pipe_ap_ready = 1'b0;
    endtask

    task automatic deliver_all(input logic [39:0] data);
        cnn_tvalid = 5'h1F; cnn_tdata = data;
        @(negedge clk);
        cnn_tvalid = 5'h00; cnn_tdata = '0;
    endtask

    task automatic finish_emit();
        res_tready = 1'b1;
        @(negedge clk);
        res_tready = 1'b0;
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_busy: got %0h want 0", busy); end
        compared++; if (ap_start !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_ap_start: got %0h want 0", ap_start); end
        compared++; if (cnn_tready !== 5'h00) begin mismatched++; $display("[TB] FAIL rst_cnn_tready: got %0h want 0", cnn_tready); end
        compared++; if (res_tvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_res_tvalid: got %0h want 0", res_tvalid); end
        compared++; if (res_tdata !== 40'h0) begin mismatched++; $display("[TB] FAIL rst_res_tdata: got %0h want 0", res_tdata); end
        compared++; if (res_tuser !== 16'h0) begin mismatched++; $display("[TB] FAIL rst_res_tuser: got %0h want 0", res_tuser); end
        compared++; if (drop_cnt !== 16'h0 || timeout_cnt !== 16'h0) begin mismatched++; $display("[TB] FAIL rst_counters: got %0h/%0h want 0/0", drop_cnt, timeout_cnt); end
        ap_rst_n = 1'b1;
        @(negedge clk);
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_release_busy: got %0h want 0", busy); end
    endtask

    task automatic test_start_strobe();
        int hi;
        hi = 0;
        start_frame(5'd3, 5'd4);
        for (int i = 0; i < 8; i++) begin
            if (ap_start === 1'b1) hi++;
            pipe_ap_ready = (i == 2);
            @(negedge clk);
        end
        pipe_ap_ready = 1'b0;
        compared++; if (hi !== 3) begin mismatched++; $display("[TB] FAIL start_strobe_len: got %0d want 3", hi); end
        compared++; if (crop_x0 !== 5'd3) begin mismatched++; $display("[TB] FAIL start_crop_x0: got %0d want 3", crop_x0); end
        compared++; if (crop_y0 !== 5'd4) begin mismatched++; $display("[TB] FAIL start_crop_y0: got %0d want 4", crop_y0); end
        compared++; if (cnn_tready !== 5'h1F) begin mismatched++; $display("[TB] FAIL start_run_tready: got %0h want 1f", cnn_tready); end
    endtask

    task automatic test_capture();
        cnn_tvalid = 5'b10000; cnn_tdata = {8'h55, 32'hEEEEEEEE};
        @(negedge clk);
        compared++; if (cnn_tready !== 5'b01111) begin mismatched++; $display("[TB] FAIL cap_tready_a: got %0h want 0f", cnn_tready); end
        cnn_tvalid = 5'b10001; cnn_tdata = {32'hEEEEEEEE, 8'h11};
        @(negedge clk);
        compared++; if (cnn_tready !== 5'b01110) begin mismatched++; $display("[TB] FAIL cap_tready_b: got %0h want 0e", cnn_tready); end
        cnn_tvalid = 5'b00110; cnn_tdata = {16'hEEEE, 8'h33, 8'h22, 8'hEE};
        @(negedge clk);
        compared++; if (cnn_tready !== 5'b01000) begin mismatched++; $display("[TB] FAIL cap_tready_c: got %0h want 08", cnn_tready); end
        cnn_tvalid = 5'b01000; cnn_tdata = {8'hEE, 8'h44, 24'hEEEEEE};
        @(negedge clk);
        cnn_tvalid = 5'b00000; cnn_tdata = '0;
        compared++; if (res_tvalid !== 1'b1) begin mismatched++; $display("[TB] FAIL cap_res_tvalid: got %0h want 1", res_tvalid); end
        compared++; if (res_tdata !== 40'h5544332211) begin mismatched++; $display("[TB] FAIL cap_res_tdata: got %0h want 5544332211", res_tdata); end
        compared++; if (res_tuser !== 16'd0) begin mismatched++; $display("[TB] FAIL cap_res_tuser: got %0d want 0", res_tuser); end
        compared++; if (cnn_tready !== 5'h00) begin mismatched++; $display("[TB] FAIL cap_emit_tready: got %0h want 0", cnn_tready); end
    endtask

    task automatic test_back_to_back();
        int stable;
        stable = 0;
        for (int i = 0; i < 10; i++) begin
            if (res_tvalid === 1'b1 && res_tdata === 40'h5544332211 && res_tuser === 16'd0) stable++;
            @(negedge clk);
        end
        compared++; if (stable !== 10) begin mismatched++; $display("[TB] FAIL hold_stable_cycles: got %0d want 10", stable); end
        compared++; if (res_tvalid !== 1'b1) begin mismatched++; $display("[TB] FAIL hold_still_valid: got %0h want 1", res_tvalid); end
        finish_emit();
        compared++; if (busy !== 1'b0 || res_tvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL hold_release: got busy %0h valid %0h want 0 0", busy, res_tvalid); end
        start_frame(5'd2, 5'd3);
        go_run();
        deliver_all(40'hA5A4A3A2A1);
        compared++; if (res_tuser !== 16'd1) begin mismatched++; $display("[TB] FAIL b2b_res_tuser: got %0d want 1", res_tuser); end
        compared++; if (res_tdata !== 40'hA5A4A3A2A1) begin mismatched++; $display("[TB] FAIL b2b_res_tdata: got %0h want a5a4a3a2a1", res_tdata); end
        finish_emit();
    endtask

    task automatic test_drop();
        start_frame(5'd5, 5'd0);
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL drop_x_busy: got %0h want 0", busy); end
        compared++; if (drop_cnt !== 16'd1) begin mismatched++; $display("[TB] FAIL drop_x_cnt: got %0d want 1", drop_cnt); end
        compared++; if (crop_x0 !== 5'd2 || crop_y0 !== 5'd3) begin mismatched++; $display("[TB] FAIL drop_x_crop: got %0d/%0d want 2/3", crop_x0, crop_y0); end
        start_frame(5'd1, 5'd2);
        go_run();
        frame_req = 1'b1; req_crop_x0 = 5'd0; req_crop_y0 = 5'd0;
        @(negedge clk);
        frame_req = 1'b0;
        compared++; if (drop_cnt !== 16'd2) begin mismatched++; $display("[TB] FAIL drop_run_cnt: got %0d want 2", drop_cnt); end
        compared++; if (cnn_tready !== 5'h1F || busy !== 1'b1) begin mismatched++; $display("[TB] FAIL drop_run_state: got tready %0h busy %0h want 1f 1", cnn_tready, busy); end
        compared++; if (crop_x0 !== 5'd1 || crop_y0 !== 5'd2) begin mismatched++; $display("[TB] FAIL drop_run_crop: got %0d/%0d want 1/2", crop_x0, crop_y0); end
        deliver_all(40'h0102030405);
        compared++; if (res_tuser !== 16'd2) begin mismatched++; $display("[TB] FAIL drop_res_tuser: got %0d want 2", res_tuser); end
        res_tready = 1'b1; frame_req = 1'b1;
        @(negedge clk);
        res_tready = 1'b0; frame_req = 1'b0;
        compared++; if (drop_cnt !== 16'd3) begin mismatched++; $display("[TB] FAIL drop_emit_cnt: got %0d want 3", drop_cnt); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL drop_emit_busy: got %0h want 0", busy); end
        start_frame(5'd0, 5'd5);
        compared++; if (drop_cnt !== 16'd4 || busy !== 1'b0) begin mismatched++; $display("[TB] FAIL drop_y_cnt: got %0d busy %0h want 4 0", drop_cnt, busy); end
        start_frame(5'd4, 5'd4);
        compared++; if (ap_start !== 1'b1 || crop_x0 !== 5'd4 || crop_y0 !== 5'd4) begin mismatched++; $display("[TB] FAIL edge_crop_accept: got start %0h crop %0d/%0d want 1 4/4", ap_start, crop_x0, crop_y0); end
        go_run();
        deliver_all(40'h1122334455);
        compared++; if (res_tuser !== 16'd3 || res_tdata !== 40'h1122334455) begin mismatched++; $display("[TB] FAIL edge_result: got %0d %0h want 3 1122334455", res_tuser, res_tdata); end
        finish_emit();
    endtask

    task automatic test_timeout();
        int  busyCycles;
        bit  sawValid;
        do_reset();
        busyCycles = 0;
        sawValid   = 1'b0;
        start_frame(5'd1, 5'd1);
        pipe_ap_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (busy === 1'b1) busyCycles++;
            if (res_tvalid !== 1'b0) sawValid = 1'b1;
            @(negedge clk);
            pipe_ap_ready = 1'b0;
        end
        compared++; if (busyCycles !== TIMEOUT_CYCLES) begin mismatched++; $display("[TB] FAIL to_busy_cycles: got %0d want %0d", busyCycles, TIMEOUT_CYCLES); end
        compared++; if (sawValid !== 1'b0) begin mismatched++; $display("[TB] FAIL to_no_result: got %0h want 0", sawValid); end
        compared++; if (timeout_cnt !== 16'd1) begin mismatched++; $display("[TB] FAIL to_cnt: got %0d want 1", timeout_cnt); end
        compared++; if (drop_cnt !== 16'd0) begin mismatched++; $display("[TB] FAIL to_drop_cnt: got %0d want 0", drop_cnt); end
        start_frame(5'd0, 5'd0);
        go_run();
        deliver_all(40'h0F0E0D0C0B);
        compared++; if (res_tuser !== 16'd1) begin mismatched++; $display("[TB] FAIL to_next_tuser: got %0d want 1", res_tuser); end
        compared++; if (res_tdata !== 40'h0F0E0D0C0B) begin mismatched++; $display("[TB] FAIL to_next_tdata: got %0h want 0f0e0d0c0b", res_tdata); end
        finish_emit();
    endtask

    task automatic test_reset_mid_frame();
        start_frame(5'd3, 5'd4);
        go_run();
        cnn_tvalid = 5'b00001; cnn_tdata = 40'h99;
        @(negedge clk);
        cnn_tvalid = 5'b00000; cnn_tdata = '0;
        frame_req = 1'b1;
        @(negedge clk);
        frame_req = 1'b0;
        #2 ap_rst_n = 1'b0;
        #1;
        compared++; if (busy !== 1'b0 || ap_start !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_rst_busy_start: got %0h %0h want 0 0", busy, ap_start); end
        compared++; if (cnn_tready !== 5'h00 || res_tvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_rst_handshake: got %0h %0h want 0 0", cnn_tready, res_tvalid); end
        compared++; if (res_tdata !== 40'h0 || res_tuser !== 16'h0) begin mismatched++; $display("[TB] FAIL mid_rst_result: got %0h %0h want 0 0", res_tdata, res_tuser); end
        compared++; if (crop_x0 !== 5'd0 || crop_y0 !== 5'd0) begin mismatched++; $display("[TB] FAIL mid_rst_crop: got %0d/%0d want 0/0", crop_x0, crop_y0); end
        compared++; if (drop_cnt !== 16'd0 || timeout_cnt !== 16'd0) begin mismatched++; $display("[TB] FAIL mid_rst_counters: got %0d/%0d want 0/0", drop_cnt, timeout_cnt); end
        @(negedge clk);
        ap_rst_n = 1'b1;
        start_frame(5'd2, 5'd2);
        go_run();
        deliver_all(40'hCAFEBABE42);
        compared++; if (res_tuser !== 16'd0) begin mismatched++; $display("[TB] FAIL mid_rst_new_tuser: got %0d want 0", res_tuser); end
        compared++; if (res_tdata !== 40'hCAFEBABE42) begin mismatched++; $display("[TB] FAIL mid_rst_new_tdata: got %0h want cafebabe42", res_tdata); end
        finish_emit();
        compared++; if (busy !== 1'b0 || drop_cnt !== 16'd0) begin mismatched++; $display("[TB] FAIL mid_rst_done: got busy %0h drop %0d want 0 0", busy, drop_cnt); end
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_start_strobe();
        test_capture();
        test_back_to_back();
        test_drop();
        test_timeout();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no completion want completion");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

endmodule
